// File: rtl/cmd_dispatch.sv
// cmd_dispatch: in-order command FIFO feeding one-hot bank FSM handshakes with read/write turnaround gaps
module cmd_dispatch #(
  parameter int DEPTH = 4,
  parameter int TURN_GAP = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  input  logic [31:0]                cmd_in,
  output logic                       cmd_ready,
  output logic [7:0]                 bank_valid,
  output logic [31:0]                bank_cmd,
  input  logic [7:0]                 bank_ready,
  output logic [$clog2(DEPTH):0]     fifo_cnt,
  output logic [15:0]                rd_cnt,
  output logic [15:0]                wr_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // command_t: r_w[31] none_0[30] row[29:17] none_1[16] burst[15] none_2[14] ap[13] col[12:3] bank[2:0]
  localparam logic [31:0] RSVD = 32'h4001_4000;

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_ISSUE} state_t;

  state_t state, state_nxt;
  logic [2:0] gap, gap_nxt;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [31:0] head;
  logic last_rw, last_rw_valid;
  logic push, pop, hs, turn;

  assign head = mem[rp];
  assign cmd_ready = fifo_cnt < CW'(DEPTH);
  assign push = cmd_valid & cmd_ready;
  assign bank_valid = (state == S_ISSUE) ? 8'b1 << bank_cmd[2:0] : 8'b0;
  assign hs = |(bank_valid & bank_ready);
  assign pop = (fifo_cnt != '0) & ((state == S_IDLE) | hs);
  // after a handshake the command just issued sets the direction, otherwise the remembered one does
  assign turn = (TURN_GAP > 0) & ((state == S_IDLE) ? (last_rw_valid & (head[31] != last_rw))
                                                    : (head[31] != bank_cmd[31]));

  // FIFO storage carries no reset; occupancy alone defines what is valid
  always_ff @(posedge clk)
    if (push) mem[wp] <= cmd_in & ~RSVD;

  // state and turnaround gap register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      gap <= '0;
    end else begin
      state <= state_nxt;
      gap <= gap_nxt;
    end

  // next state: pop decides turn vs issue, handshake with empty FIFO returns to idle, turn counts down
  always_comb begin
    state_nxt = state;
    gap_nxt = gap;
    if (pop) begin
      state_nxt = turn ? S_TURN : S_ISSUE;
      gap_nxt = turn ? 3'(TURN_GAP - 1) : gap;
    end else if (hs) begin
      state_nxt = S_IDLE;
    end else if (state == S_TURN) begin
      state_nxt = (gap == '0) ? S_ISSUE : S_TURN;
      gap_nxt = (gap == '0) ? gap : gap - 3'd1;
    end
  end

  // FIFO pointers, output register, direction history and issue counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      fifo_cnt <= '0;
      bank_cmd <= '0;
      last_rw <= 1'b0;
      last_rw_valid <= 1'b0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (pop) bank_cmd <= head;
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (hs) begin
        last_rw <= bank_cmd[31];
        last_rw_valid <= 1'b1;
        rd_cnt <= rd_cnt + 16'(bank_cmd[31]);
        wr_cnt <= wr_cnt + 16'(!bank_cmd[31]);
      end
    end
endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch: directed checks of ordering, turnaround gaps, bank handshakes and reset
module tb_cmd_dispatch;
  logic clk = 0, rst_n = 1, cmd_valid = 0;
  logic [31:0] cmd_in = '0;
  logic cmd_ready;
  logic [7:0] bank_valid, bank_ready = '0;
  logic [31:0] bank_cmd;
  logic [2:0] fifo_cnt;
  logic [15:0] rd_cnt, wr_cnt;
  int total = 0, bad = 0;
  logic [7:0] exp_gap [8] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h04, 8'h00};
  logic [31:0] c, c_exp;

  always #5 clk = ~clk;

  cmd_dispatch dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_in(cmd_in), .cmd_ready(cmd_ready),
    .bank_valid(bank_valid), .bank_cmd(bank_cmd), .bank_ready(bank_ready),
    .fifo_cnt(fifo_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  // r_w=1 is a read, r_w=0 a write; reserved, burst and auto-precharge bits left 0
  function automatic logic [31:0] mk(input logic rw, input logic [12:0] row, input logic [9:0] col, input logic [2:0] bank);
    return {rw, 1'b0, row, 4'b0, col, bank};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_cnt"}, 32'(fifo_cnt), 0);
    chk({tag, "_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_bv"}, 32'(bank_valid), 0);
    chk({tag, "_cmd"}, bank_cmd, 0);
    chk({tag, "_rd"}, 32'(rd_cnt), 0);
    chk({tag, "_wr"}, 32'(wr_cnt), 0);
  endtask

  initial begin
    #2 rst_n = 0;
    #1 reset_vals("rst");
    tick();
    tick();
    rst_n = 1;
    bank_ready = 8'hFF;
    c = mk(1'b0, 13'h0123, 10'h010, 3'd3);
    cmd_valid = 1;
    cmd_in = c;
    tick();
    cmd_valid = 0;
    chk("lat_cnt", 32'(fifo_cnt), 1);
    chk("lat_bv0", 32'(bank_valid), 0);
    tick();
    chk("lat_bv", 32'(bank_valid), 32'h08);
    chk("lat_cmd", bank_cmd, c);
    tick();
    chk("lat_wr", 32'(wr_cnt), 1);
    chk("lat_idle", 32'(bank_valid), 0);
    bank_ready = 8'hDF;
    c = mk(1'b1, 13'h1AAA, 10'h2F5, 3'd5);
    c_exp = c;
    cmd_valid = 1;
    cmd_in = c | 32'h4001_4000;
    tick();
    cmd_valid = 0;
    tick();
    tick();
    chk("b5_turn", 32'(bank_valid), 0);
    tick();
    chk("b5_bv", 32'(bank_valid), 32'h20);
    chk("rsvd_cmd", bank_cmd, c_exp);
    repeat (3) tick();
    chk("b5_hold_bv", 32'(bank_valid), 32'h20);
    chk("b5_hold_cmd", bank_cmd, c_exp);
    chk("b5_hold_rd", 32'(rd_cnt), 0);
    bank_ready = 8'hFF;
    tick();
    chk("b5_rd", 32'(rd_cnt), 1);
    chk("b5_done", 32'(bank_valid), 0);
    cmd_valid = 1;
    cmd_in = mk(1'b0, 13'h0001, 10'h001, 3'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      cmd_in = mk(1'b1, 13'h0002, 10'h002, (i == 0) ? 3'd1 : 3'd2);
      cmd_valid = (i < 2);
      tick();
      chk($sformatf("gap_%0d", i), 32'(bank_valid), 32'(exp_gap[i]));
    end
    chk("gap_rd", 32'(rd_cnt), 3);
    chk("gap_wr", 32'(wr_cnt), 2);
    bank_ready = 8'h00;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1;
      cmd_in = mk(1'b1, 13'(i + 16), 10'(i), 3'(i));
      tick();
    end
    chk("full_ready", 32'(cmd_ready), 0);
    chk("full_cnt", 32'(fifo_cnt), 4);
    cmd_in = mk(1'b1, 13'h1FFF, 10'h3FF, 3'd7);
    tick();
    chk("full_ign_cnt", 32'(fifo_cnt), 4);
    chk("full_ign_bv", 32'(bank_valid), 32'h01);
    chk("full_ign_cmd", bank_cmd, mk(1'b1, 13'd16, 10'd0, 3'd0));
    cmd_valid = 0;
    bank_ready = 8'hFF;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("ord_bv_%0d", i), 32'(bank_valid), (i < 5) ? 32'(1 << i) : 0);
      if (i < 5) chk($sformatf("ord_cmd_%0d", i), bank_cmd, mk(1'b1, 13'(i + 16), 10'(i), 3'(i)));
    end
    chk("ord_rd", 32'(rd_cnt), 8);
    bank_ready = 8'h00;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1;
      cmd_in = (i == 0) ? mk(1'b1, 13'h0040, 10'h040, 3'd6) : mk(1'b0, 13'(i), 10'(i), 3'(i - 1));
      tick();
    end
    cmd_valid = 0;
    chk("pre_cnt", 32'(fifo_cnt), 4);
    bank_ready = 8'h40;
    tick();
    chk("turn_cnt", 32'(fifo_cnt), 3);
    chk("turn_bv", 32'(bank_valid), 0);
    chk("turn_rd", 32'(rd_cnt), 9);
    bank_ready = 8'hFF;
    rst_n = 0;
    #1 reset_vals("arst");
    tick();
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("post_bv_%0d", i), 32'(bank_valid), 0);
    end
    chk("post_cnt", 32'(fifo_cnt), 0);
    chk("post_rd", 32'(rd_cnt), 0);
    chk("post_wr", 32'(wr_cnt), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 Parameter DEPTH, default 4, sets command FIFO depth (power of two, 2..16).
REQ-002 Parameter TURN_GAP, default 2, sets idle cycles inserted on read/write direction change (0..7).
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 cmd_valid  input  1  host command present.
REQ-006 cmd_in  input  32  host command, command_t packed layout (r_w, none_0, row_addr[12:0], none_1, burst_length, none_2, auto_precharge, col_addr[9:0], bank_addr[2:0]).
REQ-007 cmd_ready  output  1  FIFO can accept a command this cycle.
REQ-008 bank_valid  output  8  one-hot; bit b offers bank_cmd to bank FSM b.
REQ-009 bank_cmd  output  32  registered command_t toward the bank FSMs.
REQ-010 bank_ready  input  8  bank FSM b accepts bank_cmd.
REQ-011 fifo_cnt  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 rd_cnt, wr_cnt  output  16 each  issued read and write commands, wrapping counters.

Function
REQ-013 Push occurs on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_ready = (fifo_cnt < DEPTH), no combinational path from bank_ready.
REQ-014 FIFO preserves order across all banks; no reordering or bypass.
REQ-015 Reserved fields none_0, none_1 and none_2 are forced to 0 on write into the FIFO.
REQ-016 Dispatch FSM states: S_IDLE, S_TURN, S_ISSUE.
REQ-017 S_IDLE: on fifo_cnt>0, pop head into the output register; next state is S_TURN if head r_w differs from last_rw, last_rw_valid=1 and TURN_GAP>0; otherwise S_ISSUE.
REQ-018 S_TURN: gap counter loads TURN_GAP-1 on entry and decrements each cycle; transition to S_ISSUE when it reaches 0; bank_valid=0 throughout.
REQ-019 S_ISSUE: bank_valid = 1 << bank_cmd.bank_addr; bank_cmd stays stable until handshake.
REQ-020 Handshake = bank_valid[b] & bank_ready[b]; ready bits of other banks are ignored.
REQ-021 On handshake: last_rw <= bank_cmd.r_w, last_rw_valid <= 1, rd_cnt or wr_cnt increments (wrapping 0xFFFF->0x0000); if FIFO non-empty, pop next head the same edge and go to S_TURN/S_ISSUE per REQ-017; else go to S_IDLE.
REQ-022 Back-to-back same-direction issue sustains one command per cycle when bank_ready stays high.
REQ-023 Minimum latency: command pushed into an empty FIFO on edge k drives bank_valid high after edge k+1.
REQ-024 Simultaneous push and pop in one cycle leaves fifo_cnt unchanged; pointers wrap modulo DEPTH.
REQ-025 Push when full is impossible (cmd_ready=0); cmd_in is ignored while cmd_ready=0.
REQ-026 bank_valid is never asserted in S_IDLE or S_TURN and has at most one bit set.

Reset
REQ-027 rst_n low, asynchronously: FIFO empty, fifo_cnt=0, cmd_ready=1 after release, bank_valid=0, bank_cmd=0, rd_cnt=wr_cnt=0, last_rw_valid=0, gap counter=0, state=S_IDLE.
REQ-028 Reset mid-transfer discards all queued and in-flight commands; no partial handshake completes.

Verification
REQ-029 Push write to bank 3 (row 0x0123, col 0x010) into empty FIFO with bank_ready=0xFF -> bank_valid=0x08 after edge k+1; wr_cnt=1 one edge later.
REQ-030 Push 4 commands with bank_ready=0 -> cmd_ready=0, fifo_cnt=4 (with one more in output register); raise bank_ready -> in-order issue, one per cycle.
REQ-031 Sequence write, read, read with TURN_GAP=2 -> exactly 2 idle cycles before the read, none between the two reads.
REQ-032 Head targets bank 5, bank_ready=0xDF -> bank_valid=0x20 held with bank_cmd stable until bit 5 rises.
REQ-033 cmd_in with reserved bits set to 1 -> bank_cmd reserved bits are 0.
REQ-034 Assert rst_n=0 while S_TURN with 3 commands queued -> all outputs at REQ-027 values immediately; no issue after release.
